xfer_tbl_loader: RTL
====================

Name: xfer_tbl_loader

Overview:
- Writer side of the xfer command buffer; the xfer move sequencer is the reader.
- Accepts a downloaded byte stream of 6-byte move descriptors and writes it into one region of the xfer buffer. The regions are xfer-in, xfer-out and xnet.
- On completion, reports entry count and status so the regions can later be walked as 6-byte records.
- Sits between the configuration download path and the xfer buffer write port.

Parameters:
- ENTRY_BYTES, 6, bytes per descriptor; the alignment check uses this value.
- ADDR_W, 18, xfer buffer address width.
- CNT_W, 15, width of the entry counter.

Ports:
- sys_clk_50m  in  1  sole clock
- sys_rst_n  in  1  asynchronous active-low reset
- load_start  in  1  one-cycle pulse; latches tbl_base and tbl_max_len and starts a load
- tbl_base  in  ADDR_W  region start address
- tbl_max_len  in  ADDR_W  region size in bytes
- move_busy  in  1  reader active; high blocks buffer writes
- ld_valid  in  1  byte valid
- ld_data  in  8  byte
- ld_last  in  1  qualifies the final byte of the load
- ld_ready  out  1  byte accepted when ld_valid and ld_ready are both high
- xfer_buf_wren  out  1  write strobe
- xfer_buf_waddr  out  ADDR_W  write address
- xfer_buf_wdata  out  8  write data
- load_busy  out  1  high from load_start until done
- load_done  out  1  one-cycle completion pulse
- load_err  out  2  status: 00 ok, 01 misaligned, 10 overflow, 11 checksum
- load_entry_cnt  out  CNT_W  complete entries written

Behaviour:
- Reset values: all outputs 0. The FSM returns to IDLE. A reset mid-load abandons the load with no done pulse; bytes already written stay in the buffer.
- States are IDLE, LOAD, DRAIN and DONE.
- IDLE:
  - ld_ready=0.
  - load_start latches tbl_base and tbl_max_len, clears the offset, byte-in-entry counter, entry count and load_err, sets load_busy, and moves to LOAD.
  - load_start in any other state is ignored.
- LOAD:
  - ld_ready = !move_busy.
  - An accepted byte produces wren=1, waddr=(base+offset) mod 2^ADDR_W and wdata=ld_data on the next cycle, so write latency is 1.
  - The offset then increments. The byte-in-entry counter counts 0..5 and wraps; load_entry_cnt increments on the write of byte 5 of an entry.
  - If offset == tbl_max_len when a byte is accepted: no write occurs, load_err=10, and the FSM goes to DRAIN, or to DONE if that byte carries ld_last.
  - If an accepted byte carries ld_last: the FSM goes to DONE. If the final byte-in-entry count is not 0 and no overflow occurred, load_err=01.
  - If move_busy rises while ld_valid is high, the byte is held and not accepted, and no write occurs.
- DRAIN:
  - ld_ready=1 and no writes.
  - Bytes are discarded until ld_last is accepted, then the FSM goes to DONE.
- DONE:
  - load_done=1 for one cycle, load_busy=0, then IDLE.
  - load_err and load_entry_cnt hold their values until the next load_start.
- Error priority: overflow > misaligned > checksum.
- tbl_max_len=0: the first byte overflows.
- A zero-byte load is not possible, because ld_last always qualifies a byte.
- The last-byte write occurs in the same cycle as load_done.

Optional Feature:
- Macro: XFER_LOAD_CSUM_EN.
- When defined:
  - The byte accepted with ld_last is an 8-bit checksum and is not written.
  - The checksum must equal the mod-256 sum of all preceding written bytes; a mismatch gives load_err=11, subject to the error priority.
  - The alignment check counts only the preceding bytes.
- When undefined: every byte, including the last, is data and is written.

Test Plan:
- Normal load: base=0x01000, max_len=12, 12 bytes 0x00..0x0B with last on the 12th -> 12 writes at addresses 0x01000..0x0100B, entry_cnt=2, err=00, done pulses once.
- Backpressure: move_busy held high for 5 cycles mid-entry -> ld_ready=0 and no wren during that time, then the stream resumes with no lost or duplicated bytes.
- Misaligned: 8 bytes with last -> 8 writes, entry_cnt=1, err=01.
- Overflow: max_len=6, 10 bytes -> 6 writes, bytes 7-10 dropped, err=10, done after the 10th byte.
- Wrap: base=0x3FFFE, 6 bytes -> addresses 0x3FFFE, 0x3FFFF, 0x00000..0x00003.
- CSUM_EN: 6 bytes of 0x10 then last=0x60 -> 6 writes, err=00; repeating with last=0x61 -> err=11. Also assert reset mid-load -> outputs 0, no done pulse.

Source files
------------

// File: rtl/xfer_tbl_loader_if.sv
// Download-stream, control and xfer-buffer write-port signals of the xfer table loader.
// master = download/control side, slave = the loader.
interface xfer_tbl_loader_if #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned CNT_W  = 15
);
  logic              load_start;
  logic [ADDR_W-1:0] tbl_base;
  logic [ADDR_W-1:0] tbl_max_len;
  logic              move_busy;
  logic              ld_valid;
  logic [7:0]        ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              xfer_buf_wren;
  logic [ADDR_W-1:0] xfer_buf_waddr;
  logic [7:0]        xfer_buf_wdata;
  logic              load_busy;
  logic              load_done;
  logic [1:0]        load_err;
  logic [CNT_W-1:0]  load_entry_cnt;

  modport master (
    output load_start, tbl_base, tbl_max_len, move_busy, ld_valid, ld_data, ld_last,
    input  ld_ready, xfer_buf_wren, xfer_buf_waddr, xfer_buf_wdata,
           load_busy, load_done, load_err, load_entry_cnt
  );

  modport slave (
    input  load_start, tbl_base, tbl_max_len, move_busy, ld_valid, ld_data, ld_last,
    output ld_ready, xfer_buf_wren, xfer_buf_waddr, xfer_buf_wdata,
           load_busy, load_done, load_err, load_entry_cnt
  );
endinterface

// File: rtl/xfer_tbl_loader.sv
// Writes a downloaded stream of 6-byte move descriptors into one xfer buffer region.
// Optional trailing checksum byte: define XFER_LOAD_CSUM_EN.
module xfer_tbl_loader #(
  parameter int unsigned ENTRY_BYTES = 6,
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned CNT_W       = 15
) (
  input logic             sys_clk_50m,
  input logic             sys_rst_n,
  xfer_tbl_loader_if.slave bus_if
);

  localparam int unsigned BIE_W = (ENTRY_BYTES > 1) ? $clog2(ENTRY_BYTES) : 1;
  localparam logic [BIE_W-1:0] BIE_LAST = BIE_W'(ENTRY_BYTES - 1);
  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_MIS  = 2'b01;
  localparam logic [1:0] ERR_OVF  = 2'b10;
  localparam logic [1:0] ERR_CSUM = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] max_len_q, max_len_d;
  logic [ADDR_W-1:0] offset_q, offset_d;
  logic [BIE_W-1:0]  bie_q, bie_d;
  logic [7:0]        sum_q, sum_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        err_q, err_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;

  logic             ld_ready_c;
  logic             csum_byte_c;
  logic             csum_bad_c;
  logic [BIE_W-1:0] bie_inc_c;

`ifdef XFER_LOAD_CSUM_EN
  assign csum_byte_c = bus_if.ld_last;
`else
  assign csum_byte_c = 1'b0;
`endif
  assign csum_bad_c = (bus_if.ld_data != sum_q);
  assign bie_inc_c  = (bie_q == BIE_LAST) ? '0 : bie_q + BIE_W'(1);

  // State and output registers
  always_ff @(posedge sys_clk_50m or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      max_len_q <= '0;
      offset_q  <= '0;
      bie_q     <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      err_q     <= ERR_OK;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wren_q    <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      max_len_q <= max_len_d;
      offset_q  <= offset_d;
      bie_q     <= bie_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wren_q    <= wren_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    max_len_d  = max_len_q;
    offset_d   = offset_q;
    bie_d      = bie_q;
    sum_d      = sum_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    wren_d     = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    ld_ready_c = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus_if.load_start) begin
          base_d    = bus_if.tbl_base;
          max_len_d = bus_if.tbl_max_len;
          offset_d  = '0;
          bie_d     = '0;
          sum_d     = '0;
          cnt_d     = '0;
          err_d     = ERR_OK;
          busy_d    = 1'b1;
          state_d   = S_LOAD;
        end
      end

      S_LOAD: begin
        ld_ready_c = !bus_if.move_busy;
        if (bus_if.ld_valid && ld_ready_c) begin
          if (csum_byte_c) begin
            // Checksum byte is never written; alignment counts only preceding bytes.
            err_d   = (bie_q != '0) ? ERR_MIS : (csum_bad_c ? ERR_CSUM : ERR_OK);
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else if (offset_q == max_len_q) begin
            err_d = ERR_OVF;
            if (bus_if.ld_last) begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_DRAIN;
            end
          end else begin
            wren_d   = 1'b1;
            waddr_d  = base_q + offset_q;
            wdata_d  = bus_if.ld_data;
            offset_d = offset_q + ADDR_W'(1);
            bie_d    = bie_inc_c;
            sum_d    = sum_q + bus_if.ld_data;
            if (bie_q == BIE_LAST) cnt_d = cnt_q + CNT_W'(1);
            if (bus_if.ld_last) begin
              err_d   = (bie_inc_c != '0) ? ERR_MIS : ERR_OK;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = S_DONE;
            end
          end
        end
      end

      S_DRAIN: begin
        ld_ready_c = 1'b1;
        if (bus_if.ld_valid && bus_if.ld_last) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus_if.ld_ready       = ld_ready_c;
  assign bus_if.xfer_buf_wren  = wren_q;
  assign bus_if.xfer_buf_waddr = waddr_q;
  assign bus_if.xfer_buf_wdata = wdata_q;
  assign bus_if.load_busy      = busy_q;
  assign bus_if.load_done      = done_q;
  assign bus_if.load_err       = err_q;
  assign bus_if.load_entry_cnt = cnt_q;

endmodule
